// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush/bubble insertion and a saturating bubble counter.
// Load-use hazard detection is compiled in only when ID_EX_HAZARD_DETECT_EN is defined.
module id_ex_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        EX_control,
  input  logic [3:0]        M_control,
  input  logic [1:0]        WB_control,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic              flush,
  output logic [3:0]        ex_EX_control,
  output logic [3:0]        ex_M_control,
  output logic [1:0]        ex_WB_control,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic              ex_valid,
  output logic              hazard_stall,
  output logic [15:0]       stall_count
);

  logic bubble;

`ifdef ID_EX_HAZARD_DETECT_EN
  // A load in EX whose destination feeds the instruction in ID must wait one cycle.
  always_comb begin
    hazard_stall = ex_valid && ex_M_control[3] && (ex_rt != '0) &&
                   ((ex_rt == id_rs) || (ex_rt == id_rt));
  end
`else
  always_comb begin
    hazard_stall = 1'b0;
  end
`endif

  always_comb begin
    bubble = flush || hazard_stall;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_EX_control <= '0;
      ex_M_control  <= '0;
      ex_WB_control <= '0;
      ex_pc4        <= '0;
      ex_rd1        <= '0;
      ex_rd2        <= '0;
      ex_imm        <= '0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_rd         <= '0;
      ex_valid      <= 1'b0;
      stall_count   <= '0;
    end else begin
      // Data fields load unconditionally; only control and valid distinguish a bubble.
      ex_pc4 <= id_pc4;
      ex_rd1 <= id_rd1;
      ex_rd2 <= id_rd2;
      ex_imm <= id_imm;
      ex_rs  <= id_rs;
      ex_rt  <= id_rt;
      ex_rd  <= id_rd;
      if (bubble) begin
        ex_EX_control <= '0;
        ex_M_control  <= '0;
        ex_WB_control <= '0;
        ex_valid      <= 1'b0;
        if (stall_count != '1) stall_count <= stall_count + 16'd1;
      end else begin
        ex_EX_control <= EX_control;
        ex_M_control  <= M_control;
        ex_WB_control <= WB_control;
        ex_valid      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; expectations follow ID_EX_HAZARD_DETECT_EN.
module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic [3:0]  EX_control, M_control;
  logic [1:0]  WB_control;
  logic [31:0] id_pc4, id_rd1, id_rd2, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        flush;
  logic [3:0]  ex_EX_control, ex_M_control;
  logic [1:0]  ex_WB_control;
  logic [31:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic        ex_valid, hazard_stall;
  logic [15:0] stall_count;

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [15:0] exp_sc;

`ifdef ID_EX_HAZARD_DETECT_EN
  localparam logic HZ = 1'b1;
`else
  localparam logic HZ = 1'b0;
`endif

  id_ex_stage #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .EX_control(EX_control), .M_control(M_control), .WB_control(WB_control),
    .id_pc4(id_pc4), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
    .ex_EX_control(ex_EX_control), .ex_M_control(ex_M_control), .ex_WB_control(ex_WB_control),
    .ex_pc4(ex_pc4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_valid(ex_valid), .hazard_stall(hazard_stall), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] ex, input logic [3:0] m, input logic [1:0] wb,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] rd1);
    EX_control = ex; M_control = m; WB_control = wb;
    id_rs = rs; id_rt = rt; id_rd = rd;
    id_rd1 = rd1; id_rd2 = rd1 + 32'h100; id_imm = rd1 ^ 32'hFFFF0000; id_pc4 = rd1 + 32'h4;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ex"}, {60'd0, ex_EX_control}, 64'd0);
    chk({tag, "_m"}, {60'd0, ex_M_control}, 64'd0);
    chk({tag, "_wb"}, {62'd0, ex_WB_control}, 64'd0);
    chk({tag, "_rd1"}, {32'd0, ex_rd1}, 64'd0);
    chk({tag, "_valid"}, {63'd0, ex_valid}, 64'd0);
    chk({tag, "_sc"}, {48'd0, stall_count}, 64'd0);
    chk({tag, "_haz"}, {63'd0, hazard_stall}, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    drive(4'b1010, 4'b0000, 2'b11, 5'd1, 5'd2, 5'd3, 32'hDEADBEEF);
    #3;
    chk_zero("por");
    #20 rst_n = 1'b1;
    #1 chk("no_change_before_edge", {63'd0, ex_valid}, 64'd0);
    step();
    chk("load_deadbeef", {32'd0, ex_rd1}, 64'h0000_0000_DEADBEEF);
    #3 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    #2 rst_n = 1'b1;
    exp_sc = 16'd0;

    // R-type load
    drive(4'b1010, 4'b0000, 2'b11, 5'd1, 5'd2, 5'd3, 32'h5);
    step();
    chk("r_ex", {60'd0, ex_EX_control}, 64'hA);
    chk("r_m", {60'd0, ex_M_control}, 64'h0);
    chk("r_wb", {62'd0, ex_WB_control}, 64'h3);
    chk("r_rd1", {32'd0, ex_rd1}, 64'h5);
    chk("r_rd2", {32'd0, ex_rd2}, 64'h105);
    chk("r_imm", {32'd0, ex_imm}, 64'hFFFF0005);
    chk("r_pc4", {32'd0, ex_pc4}, 64'h9);
    chk("r_regs", {49'd0, ex_rs, ex_rt, ex_rd}, {49'd0, 5'd1, 5'd2, 5'd3});
    chk("r_valid", {63'd0, ex_valid}, 64'd1);
    chk("r_haz", {63'd0, hazard_stall}, 64'd0);

    // Load-use: LW rt=8 then ADD rs=8
    drive(4'b0001, 4'b1000, 2'b10, 5'd1, 5'd8, 5'd0, 32'h10);
    step();
    chk("lw_m", {60'd0, ex_M_control}, 64'h8);
    drive(4'b1010, 4'b0000, 2'b10, 5'd8, 5'd3, 5'd4, 32'h20);
    #1 chk("lu_haz", {63'd0, hazard_stall}, {63'd0, HZ});
`ifdef ID_EX_HAZARD_DETECT_EN
    step();
    exp_sc = exp_sc + 16'd1;
    chk("lu_bub_valid", {63'd0, ex_valid}, 64'd0);
    chk("lu_bub_ctl", {54'd0, ex_EX_control, ex_M_control, ex_WB_control}, 64'd0);
    chk("lu_bub_haz", {63'd0, hazard_stall}, 64'd0);
    chk("lu_bub_sc", {48'd0, stall_count}, {48'd0, exp_sc});
`endif
    step();
    chk("lu_add_valid", {63'd0, ex_valid}, 64'd1);
    chk("lu_add_rs", {59'd0, ex_rs}, 64'd8);
    chk("lu_add_ex", {60'd0, ex_EX_control}, 64'hA);
    chk("lu_sc", {48'd0, stall_count}, {48'd0, exp_sc});

    // LW rt=0 followed by rs=0: never a hazard
    drive(4'b0001, 4'b1000, 2'b10, 5'd2, 5'd0, 5'd0, 32'h30);
    step();
    drive(4'b1010, 4'b0000, 2'b10, 5'd0, 5'd0, 5'd5, 32'h40);
    #1 chk("r0_haz", {63'd0, hazard_stall}, 64'd0);
    step();
    chk("r0_valid", {63'd0, ex_valid}, 64'd1);
    chk("r0_rd1", {32'd0, ex_rd1}, 64'h40);
    chk("r0_sc", {48'd0, stall_count}, {48'd0, exp_sc});

    // Two consecutive dependent loads: LW rt=8, LW rs=8 rt=9, ADD rt=9
    drive(4'b0001, 4'b1000, 2'b10, 5'd1, 5'd8, 5'd0, 32'h50);
    step();
    drive(4'b0001, 4'b1000, 2'b10, 5'd8, 5'd9, 5'd0, 32'h60);
    #1 chk("dd1_haz", {63'd0, hazard_stall}, {63'd0, HZ});
`ifdef ID_EX_HAZARD_DETECT_EN
    step();
    chk("dd1_bub", {63'd0, ex_valid}, 64'd0);
    exp_sc = exp_sc + 16'd1;
`endif
    step();
    chk("dd_lw2", {58'd0, ex_valid, ex_rt}, {58'd0, 1'b1, 5'd9});
    drive(4'b1010, 4'b0000, 2'b10, 5'd7, 5'd9, 5'd6, 32'h70);
    #1 chk("dd2_haz", {63'd0, hazard_stall}, {63'd0, HZ});
`ifdef ID_EX_HAZARD_DETECT_EN
    step();
    chk("dd2_bub", {63'd0, ex_valid}, 64'd0);
    exp_sc = exp_sc + 16'd1;
`endif
    step();
    chk("dd_add", {32'd0, ex_rd1}, 64'h70);
    chk("dd_sc", {48'd0, stall_count}, {48'd0, exp_sc});

    // Flush coincident with a hazard: one bubble, count +1
    drive(4'b0001, 4'b1000, 2'b10, 5'd1, 5'd8, 5'd0, 32'h80);
    step();
    drive(4'b1010, 4'b0000, 2'b10, 5'd8, 5'd3, 5'd4, 32'h90);
    flush = 1'b1;
    #1 chk("fh_haz", {63'd0, hazard_stall}, {63'd0, HZ});
    step();
    flush = 1'b0;
    exp_sc = exp_sc + 16'd1;
    chk("fh_bub_valid", {63'd0, ex_valid}, 64'd0);
    chk("fh_bub_ctl", {54'd0, ex_EX_control, ex_M_control, ex_WB_control}, 64'd0);
    chk("fh_sc", {48'd0, stall_count}, {48'd0, exp_sc});
    drive(4'b1010, 4'b0000, 2'b10, 5'd3, 5'd3, 5'd4, 32'hA0);
    step();
    chk("fh_next_valid", {63'd0, ex_valid}, 64'd1);
    chk("fh_next_sc", {48'd0, stall_count}, {48'd0, exp_sc});

    // Reset during a pending load-use stall
    drive(4'b0001, 4'b1000, 2'b10, 5'd1, 5'd8, 5'd0, 32'hB0);
    step();
    drive(4'b1010, 4'b0000, 2'b10, 5'd8, 5'd3, 5'd4, 32'hC0);
    #1 chk("rs_haz_pre", {63'd0, hazard_stall}, {63'd0, HZ});
    #1 rst_n = 1'b0;
    #1 chk_zero("rs_mid");
    #1 rst_n = 1'b1;
    step();
    chk("rs_load_valid", {63'd0, ex_valid}, 64'd1);
    chk("rs_load_rd1", {32'd0, ex_rd1}, 64'hC0);
    chk("rs_load_sc", {48'd0, stall_count}, 64'd0);

    // Saturation of stall_count
    flush = 1'b1;
    repeat (65534) step();
    chk("sat_fffe", {48'd0, stall_count}, 64'hFFFE);
    repeat (3) step();
    chk("sat_ffff", {48'd0, stall_count}, 64'hFFFF);
    chk("sat_valid", {63'd0, ex_valid}, 64'd0);
    flush = 1'b0;
    step();
    chk("sat_hold", {48'd0, stall_count}, 64'hFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_W, default 32: width of all data/PC buses.
REQ-002 clk  in  1  rising-edge system clock.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 EX_control  in  4  EX-stage control from ID control decode; bit3 RegDst, bits2..0 ALUSrc/ALUOp.
REQ-005 M_control  in  4  memory control from ID; bit3 MemRead, bit2 MemWrite, bit1 Branch, bit0 BOP (1=BEQ, 0=BNE).
REQ-006 WB_control  in  2  writeback control from ID; bit1 RegWrite, bit0 MemtoReg.
REQ-007 id_pc4, id_rd1, id_rd2, id_imm  in  DATA_W each  PC+4, register operands, sign-extended immediate.
REQ-008 id_rs, id_rt, id_rd  in  5 each  register specifiers of the ID instruction.
REQ-009 flush  in  1  branch-taken kill of the instruction in ID.
REQ-010 ex_EX_control, ex_M_control  out  4 each; ex_WB_control  out  2  registered control.
REQ-011 ex_pc4, ex_rd1, ex_rd2, ex_imm  out  DATA_W each; ex_rs, ex_rt, ex_rd  out  5 each  registered data.
REQ-012 ex_valid  out  1  1 when EX holds a real (non-bubble) instruction.
REQ-013 hazard_stall  out  1  combinational; 1 = hold PC and IF/ID this cycle.
REQ-014 stall_count  out  16  number of bubble cycles inserted by hazard or flush.

Function
REQ-015 Each rising clk edge the stage SHALL take exactly one of three actions, priority flush > bubble > load.
REQ-016 Load: all ex_* outputs SHALL capture corresponding id_* / control inputs, ex_valid <= 1; latency exactly 1 cycle.
REQ-017 Control X bits SHALL be captured as-is on load; no masking of don't-care bits.
REQ-018 Bubble/flush: ex_EX_control, ex_M_control, ex_WB_control SHALL load 0, ex_valid <= 0; data/specifier registers MAY load id values (not checked).
REQ-019 hazard_stall SHALL be 1 iff ex_valid=1, ex_M_control[3]=1, ex_rt!=0, and (ex_rt==id_rs or ex_rt==id_rt).
REQ-020 hazard_stall=1 with flush=0 SHALL cause a bubble at the next edge.
REQ-021 flush=1 SHALL cause a bubble regardless of hazard_stall; hazard_stall output SHALL still reflect REQ-019.
REQ-022 A load-use sequence SHALL produce exactly one bubble cycle: after the bubble ex_valid=0, so hazard_stall deasserts and the held instruction loads on the following edge.
REQ-023 Two consecutive dependent loads SHALL each incur exactly one bubble.
REQ-024 stall_count SHALL increment by 1 on every bubble/flush edge and saturate at 16'hFFFF (no wrap).
REQ-025 hazard_stall SHALL be purely combinational from current registers and id_rs/id_rt; no other output is combinational.

Reset
REQ-026 rst_n=0 SHALL immediately (asynchronously) clear all ex_* outputs, ex_valid and stall_count to 0; hazard_stall consequently reads 0.
REQ-027 Reset assertion mid-stall SHALL abandon the stall; first edge after rst_n rises SHALL perform a normal load.
REQ-028 Reset deassertion SHALL be synchronous-safe: no state change before the first rising clk after rst_n=1.

Configuration
REQ-029 Macro ID_EX_HAZARD_DETECT_EN: when defined, load-use detection per REQ-019..REQ-023 is compiled in.
REQ-030 When undefined, hazard_stall SHALL be constant 0, bubbles occur only on flush, and stall_count counts flushes only.

Verification
REQ-031 Reset: rst_n=0 mid-cycle with ex_rd1=32'hDEADBEEF -> all outputs 0 without clk edge.
REQ-032 R-type load: EX=4'b1010, M=4'b0000, WB=2'b11, id_rd1=32'h5 -> next cycle ex_* equal inputs, ex_valid=1, hazard_stall=0.
REQ-033 Load-use: LW (M=4'b1000, rt=5'd8) then ADD rs=5'd8 -> hazard_stall=1 one cycle, one bubble (ex controls 0, ex_valid=0), ADD enters EX next cycle, stall_count=1.
REQ-034 LW rt=0 followed by instruction rs=0 -> hazard_stall=0, no bubble.
REQ-035 flush=1 coincident with hazard_stall=1 -> single bubble, stall_count +1 only.
REQ-036 Preload stall_count=16'hFFFE, three flushes -> stall_count holds 16'hFFFF; macro undefined build: load-use pair -> no bubble.
